// File: rtl/spi_target.sv
// SPI mode-3 target: synchronises the bus pins into clk, deserialises MOSI
// and serialises a one-deep TX holding register onto MISO.
module spi_target #(
  parameter int               WIDTH     = 8,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] TX_IDLE   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_clk,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic             frame_start,
  output logic             frame_end,
  output logic             frame_abort
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  logic [2:0]       sck_q;
  logic [2:0]       cs_q;
  logic [1:0]       mosi_q;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             first_q, first_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic             miso_q, miso_d;
  logic             oe_q, oe_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             full_q, full_d;
  logic             under_q, under_d;
  logic             start_q, start_d;
  logic             end_q, end_d;
  logic             abort_q, abort_d;

  logic             sck_rise, sck_fall;
  logic             cs_rise, cs_fall;
  logic             mosi_s;
  logic             do_load;
  logic [WIDTH-1:0] load_word;
  logic [WIDTH-1:0] rx_next;
  logic [WIDTH-1:0] tx_next;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // CS sync resets low so a CS already low at release never looks like a fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_q  <= 3'b111;
      cs_q   <= 3'b000;
      mosi_q <= 2'b00;
    end else begin
      sck_q  <= {sck_q[1:0], spi_clk};
      cs_q   <= {cs_q[1:0], spi_cs_n};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];
  assign mosi_s   = mosi_q[1];

  assign load_word = full_q ? hold_q : TX_IDLE;
  assign rx_next   = MSB_FIRST ? {rx_sh_q[WIDTH-2:0], mosi_s}
                               : {mosi_s, rx_sh_q[WIDTH-1:1]};
  assign tx_next   = MSB_FIRST ? {tx_sh_q[WIDTH-2:0], 1'b1}
                               : {1'b1, tx_sh_q[WIDTH-1:1]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    hold_d     = hold_q;
    full_d     = full_q;
    under_d    = 1'b0;
    start_d    = 1'b0;
    end_d      = 1'b0;
    abort_d    = 1'b0;
    do_load    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          start_d = 1'b1;
          cnt_d   = '0;
          first_d = 1'b1;
          do_load = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          end_d   = 1'b1;
          abort_d = (cnt_q != '0);
          cnt_d   = '0;
          miso_d  = 1'b1;
          oe_d    = 1'b0;
          state_d = IDLE;
        end else if (sck_rise) begin
          rx_sh_d = rx_next;
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_d      = '0;
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (sck_fall) begin
          first_d = 1'b0;
          if (cnt_q != '0) begin
            tx_sh_d = tx_next;
            miso_d  = first_bit(tx_next);
          end else if (!first_q) begin
            do_load = 1'b1;
          end
        end
      end
    endcase

    if (do_load) begin
      tx_sh_d = load_word;
      miso_d  = first_bit(load_word);
      oe_d    = 1'b1;
      under_d = ~full_q;
    end

    // accept only when empty, so it never collides with a load from hold
    if (tx_valid && !full_q) begin
      hold_d = tx_data;
      full_d = 1'b1;
    end else if (do_load && full_q) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      rx_sh_q    <= '0;
      tx_sh_q    <= '0;
      miso_q     <= 1'b1;
      oe_q       <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      hold_q     <= '0;
      full_q     <= 1'b0;
      under_q    <= 1'b0;
      start_q    <= 1'b0;
      end_q      <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      rx_sh_q    <= rx_sh_d;
      tx_sh_q    <= tx_sh_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      hold_q     <= hold_d;
      full_q     <= full_d;
      under_q    <= under_d;
      start_q    <= start_d;
      end_q      <= end_d;
      abort_q    <= abort_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = ~full_q;
  assign tx_underrun = under_q;
  assign frame_start = start_q;
  assign frame_end   = end_q;
  assign frame_abort = abort_q;

endmodule
